// File: rtl/seq_divider32.sv
// seq_divider32 -- multi-cycle restoring divider for the DIV/DIVU path in EX.
//
// Produces one quotient bit per clock. Signed operands are reduced to
// magnitudes on acceptance and the signs are reapplied in the FIX state,
// giving truncation toward zero with the remainder taking the dividend's sign.
// Each trial subtraction is an addition of the inverted divisor with a carry-in of 1.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   i_start      start request, sampled only while idle
//   i_signed     1 = signed (DIV), 0 = unsigned (DIVU), sampled with i_start
//   i_dividend   dividend, sampled with i_start
//   i_divisor    divisor, sampled with i_start
//   o_busy       high from the accepting edge until the edge that raises o_done
//   o_done       one-cycle pulse marking valid results
//   o_quotient   quotient (LO), held until the next completion
//   o_remainder  remainder (HI), held until the next completion
//   o_div_zero   set with o_done for a zero divisor, held until the next completion
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    localparam int CW = 6;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]   ONE_X = (WIDTH + 1)'(1);
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] rem_q;      // partial remainder; always < divisor
    logic [WIDTH-1:0] quo_q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr_q;      // divisor magnitude
    logic [CW-1:0]    cnt_q;
    logic             signed_q;
    logic             dvd_sign_q;
    logic             dsr_sign_q;
    logic             dz_q;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             trial_neg;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign dividend_mag = (i_signed && i_dividend[WIDTH-1]) ? ~i_dividend + ONE : i_dividend;
    assign divisor_mag  = (i_signed && i_divisor[WIDTH-1])  ? ~i_divisor + ONE  : i_divisor;

    // The remainder is kept at WIDTH bits because it never reaches the divisor;
    // the extra top bit appears only in the shifted value and the trial result.
    // Since rem < divisor, the true difference lies strictly between -2^WIDTH and
    // 2^WIDTH, so bit WIDTH of the wrapped sum is a reliable sign bit.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign trial     = rem_shift + {1'b1, ~dsr_q} + ONE_X;
    assign trial_neg = trial[WIDTH];

    assign quo_fix = (signed_q && (dvd_sign_q ^ dsr_sign_q)) ? ~quo_q + ONE : quo_q;
    assign rem_fix = (signed_q && dvd_sign_q) ? ~rem_q + ONE : rem_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = (i_divisor == '0) ? FIX : CALC;
            CALC:    if (cnt_q == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            signed_q    <= 1'b0;
            dvd_sign_q  <= 1'b0;
            dsr_sign_q  <= 1'b0;
            dz_q        <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_div_zero  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        signed_q   <= i_signed;
                        dvd_sign_q <= i_dividend[WIDTH-1];
                        dsr_sign_q <= i_divisor[WIDTH-1];
                        rem_q      <= '0;
                        dsr_q      <= divisor_mag;
                        cnt_q      <= '0;
                        o_busy     <= 1'b1;
                        dz_q       <= (i_divisor == '0);
                        // A zero divisor skips CALC, so the raw dividend is kept
                        // here to be returned as the remainder.
                        quo_q      <= (i_divisor == '0) ? i_dividend : dividend_mag;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (trial_neg) begin
                        rem_q <= rem_shift[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_q <= trial[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end
                end
                FIX: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    if (dz_q) begin
                        o_quotient  <= '1;
                        o_remainder <= quo_q;
                        o_div_zero  <= 1'b1;
                    end else begin
                        o_quotient  <= quo_fix;
                        o_remainder <= rem_fix;
                        o_div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
// tb_seq_divider32 -- directed bench for seq_divider32 with a result scoreboard.
// Expected results come from a 64-bit reference division model and are queued
// when an operation is launched, then popped when o_done pulses.
module tb_seq_divider32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_signed = 1'b0;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor = '0;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_div_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_start     (i_start),
        .i_signed    (i_signed),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_div_zero  (o_div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint na, nb;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            if (sgn) begin
                na = longint'($signed(a));
                nb = longint'($signed(b));
            end else begin
                na = longint'({32'd0, a});
                nb = longint'({32'd0, b});
            end
            e.q  = 32'(na / nb);
            e.r  = 32'(na % nb);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Called at a negedge; the start is accepted at the following posedge and
    // the task returns at the negedge after that edge.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            input bit push);
        i_signed   = sgn;
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        if (push) sb.push_back(model(sgn, a, b));
        @(negedge clk);
        i_start    = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
    endtask

    // Counts negedges until o_done, checks latency, busy, and the scoreboard head.
    task automatic wait_done(input string tag, input int exp_lat);
        int   k = 0;
        bit   busy_ok = 1'b1;
        exp_t e;
        while (!o_done && k < 40) begin
            if (!o_busy) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 128'(k), 128'(exp_lat));
        check({tag, "_busy_during"}, 128'(busy_ok), 128'd1);
        check({tag, "_busy_at_done"}, 128'(o_busy), 128'd0);
        check({tag, "_sb_has_entry"}, 128'(sb.size() > 0), 128'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_quotient"}, 128'(o_quotient), 128'(e.q));
            check({tag, "_remainder"}, 128'(o_remainder), 128'(e.r));
            check({tag, "_div_zero"}, 128'(o_div_zero), 128'(e.dz));
        end
    endtask

    task automatic done_low(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 128'(o_done), 128'd0);
    endtask

    initial begin
        bit          saw_done;
        logic        rs;
        logic [31:0] ra, rb;

        #12;
        check("reset_outputs", 128'({o_busy, o_done, o_div_zero, o_quotient, o_remainder}), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        start_op(1'b0, 32'd100, 32'd7, 1'b1);
        wait_done("u100_7", 33);
        check("u100_7_q_const", 128'(o_quotient), 128'd14);
        check("u100_7_r_const", 128'(o_remainder), 128'd2);
        done_low("u100_7");

        start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("s_m7_2", 33);
        done_low("s_m7_2");

        start_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_done("s_7_m2", 33);
        done_low("s_7_m2");

        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("s_ovf", 33);
        check("s_ovf_q_const", 128'(o_quotient), 128'h8000_0000);
        done_low("s_ovf");

        start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("u_big", 33);
        done_low("u_big");

        start_op(1'b0, 32'd1234, 32'd0, 1'b1);
        wait_done("dz", 1);
        done_low("dz");
        check("dz_flag_held", 128'(o_div_zero), 128'd1);
        check("dz_q_held", 128'(o_quotient), 128'hFFFF_FFFF);

        start_op(1'b0, 32'd10, 32'd3, 1'b1);
        wait_done("u10_3", 33);
        done_low("u10_3");

        // A second start at cycle 10 of a busy operation must be ignored.
        start_op(1'b1, 32'hFFFF_FC18, 32'd3, 1'b1);
        repeat (9) @(negedge clk);
        i_signed   = 1'b0;
        i_dividend = 32'd55;
        i_divisor  = 32'd5;
        i_start    = 1'b1;
        @(negedge clk);
        i_start    = 1'b0;
        wait_done("ignored_start", 23);
        // Start issued in the o_done cycle is accepted immediately.
        start_op(1'b0, 32'd77777, 32'd123, 1'b1);
        check("ignored_start_done_pulse", 128'(o_done), 128'd0);
        wait_done("b2b", 33);
        done_low("b2b");

        // Reset in the middle of an operation aborts it with no completion.
        start_op(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrun_reset_outputs",
              128'({o_busy, o_done, o_div_zero, o_quotient, o_remainder}), 128'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (o_done) saw_done = 1'b1;
        end
        check("no_done_after_reset", 128'(saw_done), 128'd0);
        start_op(1'b0, 32'd9, 32'd4, 1'b1);
        wait_done("u9_4", 33);
        done_low("u9_4");

        for (int i = 0; i < 4; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'd0) rb = 32'd13;
            start_op(rs, ra, rb, 1'b1);
            wait_done($sformatf("rand%0d", i), 33);
            done_low($sformatf("rand%0d", i));
        end

        check("sb_drained", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_divider32.md
Name: seq_divider32

Overview:
- Multi-cycle 32-bit integer divider for the pipeline CPU's DIV/DIVU path.
- Produces quotient (LO) and remainder (HI) by restoring division, one quotient bit per clock.
- Each trial subtraction is performed as an addition of the inverted divisor with carry-in 1, through the team's 32-bit adder datapath.
- Sits beside the ALU in EX; the hazard unit stalls on o_busy.

Parameters:
- WIDTH, 32, operand/result width; only 32 is required to be supported.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- i_start  input  1  start request; sampled only in IDLE
- i_signed  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with i_start
- i_dividend  input  32  dividend; sampled with i_start
- i_divisor  input  32  divisor; sampled with i_start
- o_busy  output  1  high from the edge that accepts a start until the edge that raises o_done
- o_done  output  1  one-cycle pulse; results valid
- o_quotient  output  32  quotient (LO)
- o_remainder  output  32  remainder (HI)
- o_div_zero  output  1  set with o_done when divisor was 0; held until next completion

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE; o_busy, o_done, o_div_zero = 0; o_quotient = o_remainder = 0; internal registers cleared. Reset mid-operation aborts immediately, and no o_done follows.
- States: IDLE, CALC, FIX.
- IDLE:
  - On an edge with i_start=1: latch i_signed and operand sign bits.
  - Load dividend magnitude into the quotient shift register and clear the 33-bit partial remainder.
  - Load divisor magnitude; clear the iteration counter (6 bits); o_busy<=1.
  - If i_divisor==0, go to FIX with a div-zero flag; otherwise go to CALC.
  - Magnitude = two's-complement negate when i_signed=1 and the sign bit is set; else the raw value.
- CALC, each edge:
  - Shift {rem, quo} left by 1.
  - trial = rem_shifted − {1'b0, divisor} (33-bit).
  - If trial ≥ 0: rem <= trial, quo[0] <= 1. Else: rem unchanged (restore), quo[0] <= 0.
  - Counter increments; after the 32nd iteration (counter==31), go to FIX.
- FIX, one edge; o_done<=1, o_busy<=0, state<=IDLE:
  - Normal case, signed: quotient negated if dividend sign XOR divisor sign; remainder negated if dividend sign (truncation toward zero; remainder takes dividend's sign).
  - Normal case, unsigned: raw values.
  - Div-zero case: o_quotient = 0xFFFFFFFF, o_remainder = original dividend, o_div_zero = 1.
- Latency:
  - Start accepted at edge N; o_done high in the cycle after edge N+33, i.e. 33 cycles from acceptance to result.
  - Div-zero: o_done high after edge N+1.
- o_done deasserts at the next edge. Outputs hold their values until the next FIX edge. o_div_zero is cleared on any non-zero completion.
- i_start while o_busy=1 is ignored; operands are not resampled.
- i_start in the same cycle o_done is high is accepted, since state is IDLE. Back-to-back operation is legal.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: magnitudes 2^31 / 1 give quotient 2^31, negated to 0x80000000; remainder 0. No trap or flag.
- Operand inputs may change freely after acceptance.

Test Plan:
- Unsigned 100 / 7 (i_signed=0) → after 33 cycles o_done pulses 1 cycle; o_quotient=14, o_remainder=2, o_div_zero=0; o_busy high throughout.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → o_quotient=0xFFFFFFFD, o_remainder=0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- 0x80000000 / 0xFFFFFFFF: signed → q=0x80000000, r=0; unsigned → q=0, r=0x80000000.
- 1234 / 0 → o_done after 1 cycle; q=0xFFFFFFFF, r=1234, o_div_zero=1. A following 10/3 clears o_div_zero (q=3, r=1).
- Second i_start with different operands at cycle 10 of a busy operation → ignored; first result unchanged. A new start asserted during the o_done cycle → accepted; its result appears 33 cycles later.
- reset_n low at cycle 15 of an operation → all outputs 0 immediately; no o_done after release; a fresh 9/4 then yields q=2, r=1.
